game_flow_ctrl: RTL and testbench



---
 rtl/snake_pkg.sv | 19 +
 rtl/game_flow_ctrl_tick_gen.sv | 47 ++++
 rtl/game_flow_ctrl.sv | 129 ++++++++++++
 tb/tb_game_flow_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared types for the snake game: screen states (also the display-mux select)
// and IR remote key codes.
package snake_pkg;

  typedef enum logic [1:0] {
    START_SCREEN = 2'd0,
    GAME_SCREEN  = 2'd1,
    PAUSE_SCREEN = 2'd2,
    END_SCREEN   = 2'd3
  } state_t;

  localparam logic [31:0] KEY_START_CODE = 32'h20DF0000;
  localparam logic [31:0] KEY_PAUSE_CODE = 32'h20DF8000;

  function automatic logic [7:0] max8(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/game_flow_ctrl_tick_gen.sv
// Programmable-period step pulse: counts up while enabled, one-cycle tick at
// period-1, clear has priority and never produces a tick.
module tick_gen (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        clr,
  input  logic [31:0] period,
  output logic        tick
);

  logic [31:0] cnt_q, cnt_d;
  logic        tick_q, tick_d;
  logic [31:0] last;

  assign last = period - 32'd1;

  // >= rather than == so a period that shrinks below the running count
  // terminates on the next enabled cycle instead of wrapping.
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q >= last) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/game_flow_ctrl.sv
// Snake game top-level sequencer: IR command decode, screen FSM, speed level,
// step tick, score and high score.
//
//   state        | meaning
//   START_SCREEN | idle after reset, waiting for start key
//   GAME_SCREEN  | game running, step ticks issued
//   PAUSE_SCREEN | game frozen, tick counter held
//   END_SCREEN   | collision seen, high score latched
module game_flow_ctrl
  import snake_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 12_500_000,
  parameter int unsigned TICK_STEP  = 1_000_000,
  parameter int unsigned MAX_LEVEL  = 8,
  parameter logic [31:0] KEY_START  = KEY_START_CODE,
  parameter logic [31:0] KEY_PAUSE  = KEY_PAUSE_CODE,
  parameter int unsigned SCORE_MULT = 5
) (
  input  logic        CLOCK_50,
  input  logic        reset_n,
  input  logic [31:0] cmd_word,
  input  logic        cmd_valid,
  input  logic        game_over,
  input  logic        food_eaten,
  input  logic [7:0]  length,
  output logic [1:0]  disp_sel,
  output logic        game_tick,
  output logic        game_clr,
  output logic [7:0]  score,
  output logic [7:0]  high_score
);

  localparam int unsigned      LVL_W   = $clog2(MAX_LEVEL + 1);
  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(MAX_LEVEL);
  localparam logic [7:0]       MULT8   = 8'(SCORE_MULT);

  state_t            state_q, state_d;
  logic              clr_q, clr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [7:0]        score_q, score_d;
  logic [7:0]        high_q, high_d;
  logic              cmd_start, cmd_pause;
  logic              tick_en;
  logic [31:0]       period;

  assign cmd_start = cmd_valid && (cmd_word == KEY_START);
  assign cmd_pause = cmd_valid && (cmd_word == KEY_PAUSE);

  always_comb begin
    state_d = state_q;
    clr_d   = 1'b0;
    level_d = level_q;
    high_d  = high_q;
    score_d = length * MULT8;
    case (state_q)
      START_SCREEN: begin
        if (cmd_start) begin
          state_d = GAME_SCREEN;
          clr_d   = 1'b1;
          level_d = '0;
        end
      end
      GAME_SCREEN: begin
        if (food_eaten && (level_q != LVL_MAX)) begin
          level_d = level_q + LVL_W'(1);
        end
        if (game_over) begin
          state_d = END_SCREEN;
          high_d  = max8(high_q, score_q);
        end else if (cmd_pause) begin
          state_d = PAUSE_SCREEN;
        end
      end
      PAUSE_SCREEN: begin
        if (cmd_start) begin
          state_d = GAME_SCREEN;
          clr_d   = 1'b1;
          level_d = '0;
        end else if (cmd_pause) begin
          state_d = GAME_SCREEN;
        end
      end
      END_SCREEN: begin
        if (cmd_start) begin
          state_d = GAME_SCREEN;
          clr_d   = 1'b1;
          level_d = '0;
        end
      end
      default: state_d = START_SCREEN;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state_q <= START_SCREEN;
      clr_q   <= 1'b0;
      level_q <= '0;
      score_q <= '0;
      high_q  <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      level_q <= level_d;
      score_q <= score_d;
      high_q  <= high_d;
    end
  end

  // Counting only on cycles that stay in the game: a pause, restart or
  // collision edge leaves the count untouched and can never emit a tick.
  assign tick_en = (state_q == GAME_SCREEN) && (state_d == GAME_SCREEN);
  assign period  = TICK_DIV - (32'(level_q) * TICK_STEP);

  tick_gen u_tick_gen (
    .clk    (CLOCK_50),
    .rst_n  (reset_n),
    .en     (tick_en),
    .clr    (clr_d),
    .period (period),
    .tick   (game_tick)
  );

  assign disp_sel   = state_q;
  assign game_clr   = clr_q;
  assign score      = score_q;
  assign high_score = high_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl: expected tick cycles are queued as
// stimulus is driven and matched against every observed game_tick.
module tb_game_flow_ctrl;

  localparam logic [31:0] K_START = 32'h20DF0000;
  localparam logic [31:0] K_PAUSE = 32'h20DF8000;

  logic        CLOCK_50 = 1'b0;
  logic        reset_n;
  logic [31:0] cmd_word;
  logic        cmd_valid;
  logic        game_over;
  logic        food_eaten;
  logic [7:0]  length;
  logic [1:0]  disp_sel;
  logic        game_tick;
  logic        game_clr;
  logic [7:0]  score;
  logic [7:0]  high_score;

  int cyc      = 0;
  int n_assert = 0;
  int n_fail   = 0;
  int exp_q[$];

  game_flow_ctrl #(
    .TICK_DIV  (10),
    .TICK_STEP (2),
    .MAX_LEVEL (3)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .reset_n    (reset_n),
    .cmd_word   (cmd_word),
    .cmd_valid  (cmd_valid),
    .game_over  (game_over),
    .food_eaten (food_eaten),
    .length     (length),
    .disp_sel   (disp_sel),
    .game_tick  (game_tick),
    .game_clr   (game_clr),
    .score      (score),
    .high_score (high_score)
  );

  always #5 CLOCK_50 = ~CLOCK_50;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // Tick scoreboard: every observed tick must match the oldest expected cycle.
  always @(negedge CLOCK_50) begin
    if (game_tick === 1'b1) begin
      n_assert++;
      assert (exp_q.size() != 0)
      else begin
        n_fail++;
        $error("FAIL unexpected_tick observed=cycle %0d expected=no tick", cyc);
      end
      if (exp_q.size() != 0) begin
        int e;
        e = exp_q.pop_front();
        n_assert++;
        assert (cyc === e)
        else begin
          n_fail++;
          $error("FAIL tick_cycle observed=%0d expected=%0d", cyc, e);
        end
        n_assert++;
        assert (game_clr === 1'b0)
        else begin
          n_fail++;
          $error("FAIL tick_with_clr observed=%b expected=0", game_clr);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic send_cmd(input logic [31:0] w);
    cmd_word  = w;
    cmd_valid = 1'b1;
    @(negedge CLOCK_50);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge CLOCK_50);
  endtask

  initial begin
    int e, t, r, s;
    int per[5];
    per = '{8, 6, 4, 4, 4};

    reset_n    = 1'b0;
    cmd_word   = '0;
    cmd_valid  = 1'b0;
    game_over  = 1'b0;
    food_eaten = 1'b0;
    length     = 8'd0;
    step(3);
    check("rst_disp", 32'(disp_sel), 0);
    check("rst_tick", 32'(game_tick), 0);
    check("rst_clr", 32'(game_clr), 0);
    check("rst_score", 32'(score), 0);
    check("rst_high", 32'(high_score), 0);
    reset_n = 1'b1;
    step(2);

    // start: clear pulse and ticks every 10 cycles
    send_cmd(K_START);
    e = cyc;
    check("start_disp", 32'(disp_sel), 1);
    check("start_clr", 32'(game_clr), 1);
    step(1);
    check("start_clr_once", 32'(game_clr), 0);
    exp_q.push_back(e + 10);
    exp_q.push_back(e + 20);
    exp_q.push_back(e + 30);
    wait_until(e + 30);
    t = e + 30;

    // pause after 4 counts, game_over ignored while paused, resume
    step(4);
    send_cmd(K_PAUSE);
    check("pause_disp", 32'(disp_sel), 2);
    check("t1_ticks_done", 32'(exp_q.size()), 0);
    game_over = 1'b1;
    step(3);
    check("pause_ignores_over", 32'(disp_sel), 2);
    game_over = 1'b0;
    step(47);
    check("pause_still", 32'(disp_sel), 2);
    send_cmd(K_PAUSE);
    r = cyc;
    check("resume_disp", 32'(disp_sel), 1);
    exp_q.push_back(r + 6);
    exp_q.push_back(r + 16);
    wait_until(r + 16);
    t = r + 16;

    // speed levels: food at a tick cycle, next tick one new period later
    for (int i = 0; i < 5; i++) begin
      food_eaten = 1'b1;
      step(1);
      food_eaten = 1'b0;
      exp_q.push_back(t + per[i]);
      wait_until(t + per[i]);
      t = t + per[i];
    end
    step(1);
    check("level_ticks_done", 32'(exp_q.size()), 0);

    // game_over with pause in the cycle a tick would fire
    length = 8'd12;
    step(2);
    game_over = 1'b1;
    cmd_word  = K_PAUSE;
    cmd_valid = 1'b1;
    step(1);
    cmd_valid = 1'b0;
    check("over_disp", 32'(disp_sel), 3);
    check("over_no_tick", 32'(game_tick), 0);
    check("over_score", 32'(score), 60);
    check("over_high", 32'(high_score), 60);
    step(2);
    send_cmd(K_PAUSE);
    check("over_ignores_pause", 32'(disp_sel), 3);
    game_over = 1'b0;
    length    = 8'd4;
    step(2);
    send_cmd(K_START);
    check("restart_disp", 32'(disp_sel), 1);
    check("restart_clr", 32'(game_clr), 1);
    step(2);
    game_over = 1'b1;
    step(1);
    game_over = 1'b0;
    check("over2_disp", 32'(disp_sel), 3);
    check("over2_score", 32'(score), 20);
    check("over2_high_kept", 32'(high_score), 60);

    // reset three cycles before a tick
    send_cmd(K_START);
    s = cyc;
    check("run3_clr", 32'(game_clr), 1);
    exp_q.push_back(s + 10);
    wait_until(s + 16);
    reset_n = 1'b0;
    step(1);
    check("midrst_disp", 32'(disp_sel), 0);
    check("midrst_tick", 32'(game_tick), 0);
    check("midrst_clr", 32'(game_clr), 0);
    check("midrst_score", 32'(score), 0);
    check("midrst_high", 32'(high_score), 0);
    reset_n = 1'b1;
    step(10);
    check("midrst_no_ticks", 32'(exp_q.size()), 0);
    check("midrst_disp_hold", 32'(disp_sel), 0);

    // score truncation and ignored commands in START
    length = 8'd60;
    step(2);
    check("score_wrap", 32'(score), 44);
    cmd_word  = K_START;
    cmd_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(10);
      check("held_word_no_strobe", 32'(disp_sel), 0);
    end
    send_cmd(32'h1234_5678);
    check("unknown_word", 32'(disp_sel), 0);
    send_cmd(K_PAUSE);
    check("pause_in_start", 32'(disp_sel), 0);
    send_cmd(K_START);
    check("final_start_disp", 32'(disp_sel), 1);
    check("final_start_clr", 32'(game_clr), 1);
    step(1);
    check("final_queue", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
